// File: rtl/csa_final_adder_if.sv
// Handshake bundle between the carry-save compressor, the chunked final adder and its consumer.
// The design side uses the slave modport; the producer/consumer side uses master.
interface csa_final_adder_if #(
    parameter int OutputWidth = 12
);
    logic                   in_valid;
    logic                   in_ready;
    logic [OutputWidth-1:0] vector0;
    logic [OutputWidth-1:0] vector1;
    logic                   out_valid;
    logic                   out_ready;
    logic [OutputWidth:0]   result;
    logic                   busy;

    modport slave (
        input  in_valid, vector0, vector1, out_ready,
        output in_ready, out_valid, result, busy
    );

    modport master (
        output in_valid, vector0, vector1, out_ready,
        input  in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/csa_final_adder.sv
// Multi-cycle chunked carry-propagate adder resolving a carry-save vector pair, one slice per clock.
// Optional CSA_EARLY_DONE_EN: finish early once the carry is dead and all higher operand slices are zero.
//
// state | meaning
// IDLE  | waiting for a vector pair, in_ready high
// ADD   | adding one ChunkWidth slice per clock
// DONE  | result presented, waiting for out_ready
module csa_final_adder #(
    parameter int OutputWidth = 12,
    parameter int ChunkWidth  = 4
) (
    input  logic clk,
    input  logic rst_n,
    csa_final_adder_if.slave io
);
    localparam int NumChunks = (OutputWidth + ChunkWidth - 1) / ChunkWidth;
    localparam int PadWidth  = NumChunks * ChunkWidth;
    localparam int IdxWidth  = (NumChunks > 1) ? $clog2(NumChunks) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t                state_q, state_d;
    logic [PadWidth-1:0]   a_q, a_d;
    logic [PadWidth-1:0]   b_q, b_d;
    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic                  carry_q, carry_d;
    // Bit PadWidth holds the last slice's carry; with a padded top chunk the real
    // carry-out lands in bit OutputWidth of the slices instead, so result taps [OutputWidth:0].
    logic [PadWidth:0]     sum_q, sum_d;

    logic [ChunkWidth-1:0] slice_a, slice_b;
    logic [ChunkWidth:0]   slice_sum;

`ifdef CSA_EARLY_DONE_EN
    logic [PadWidth-1:0]   ab_or;
    logic [NumChunks-1:0]  upper_zero;
    logic                  rest_zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int k = 0; k < NumChunks; k++) begin
            if (idx_q == IdxWidth'(k)) begin
                slice_a = a_q[k*ChunkWidth +: ChunkWidth];
                slice_b = b_q[k*ChunkWidth +: ChunkWidth];
            end
        end
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{ChunkWidth{1'b0}}, carry_q};
    end

`ifdef CSA_EARLY_DONE_EN
    always_comb begin
        ab_or      = a_q | b_q;
        upper_zero = '0;
        rest_zero  = 1'b0;
        for (int k = 0; k < NumChunks; k++) begin
            upper_zero[k] = ((ab_or >> ((k + 1) * ChunkWidth)) == '0);
            if (idx_q == IdxWidth'(k)) begin
                rest_zero = upper_zero[k];
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    a_d     = PadWidth'(io.vector0);
                    b_d     = PadWidth'(io.vector1);
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int k = 0; k < NumChunks; k++) begin
                    if (idx_q == IdxWidth'(k)) begin
                        sum_d[k*ChunkWidth +: ChunkWidth] = slice_sum[ChunkWidth-1:0];
                    end
                end
                carry_d = slice_sum[ChunkWidth];
                idx_d   = idx_q + IdxWidth'(1);
                if (idx_q == IdxWidth'(NumChunks - 1)) begin
                    sum_d[PadWidth] = slice_sum[ChunkWidth];
                    idx_d           = '0;
                    state_d         = DONE;
                end
`ifdef CSA_EARLY_DONE_EN
                else if (!slice_sum[ChunkWidth] && rest_zero) begin
                    for (int k = 0; k < NumChunks; k++) begin
                        if (IdxWidth'(k) > idx_q) begin
                            sum_d[k*ChunkWidth +: ChunkWidth] = '0;
                        end
                    end
                    sum_d[PadWidth] = 1'b0;
                    idx_d           = '0;
                    state_d         = DONE;
                end
`endif
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.busy      = (state_q != IDLE);
    assign io.result    = sum_q[OutputWidth:0];
endmodule

// File: tb/tb_csa_final_adder.sv
// Directed bench for csa_final_adder: reset, carry ripple, overflow MSB, backpressure, back-to-back.
// Expected latencies follow CSA_EARLY_DONE_EN when it is defined for the build.
module tb_csa_final_adder;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   lat;

`ifdef CSA_EARLY_DONE_EN
    localparam int LatSmall = 1;
`else
    localparam int LatSmall = 3;
`endif

    csa_final_adder_if #(.OutputWidth(12)) bus ();

    csa_final_adder #(.OutputWidth(12), .ChunkWidth(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a pair and take the accepting edge; returns at #1 after that edge.
    task automatic accept(input logic [11:0] v0, input logic [11:0] v1);
        bus.vector0  = v0;
        bus.vector1  = v1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges until out_valid is seen; 0 means the bound expired.
    task automatic wait_valid(output int edges);
        edges = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                edges = n;
                break;
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.vector0   = '0;
        bus.vector1   = '0;
        bus.out_ready = 1'b1;

        #1;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_result", {19'b0, bus.result}, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);

        // carry ripple across all three chunks
        @(negedge clk);
        accept(12'h0FF, 12'h001);
        check("ripple_busy", {31'b0, bus.busy}, 32'h1);
        check("ripple_in_ready_add", {31'b0, bus.in_ready}, 32'h0);
        wait_valid(lat);
        check("ripple_latency", lat, 3);
        check("ripple_result", {19'b0, bus.result}, 32'h0100);
        @(posedge clk);
        #1;
        check("ripple_valid_pulse", {31'b0, bus.out_valid}, 32'h0);
        check("ripple_in_ready_after", {31'b0, bus.in_ready}, 32'h1);

        // full-scale operands set the carry-out MSB
        @(negedge clk);
        accept(12'hFFF, 12'hFFF);
        wait_valid(lat);
        check("max_latency", lat, 3);
        check("max_result", {19'b0, bus.result}, 32'h1FFE);
        @(posedge clk);
        #1;

        // backpressure: result and handshake outputs held while out_ready low
        @(negedge clk);
        bus.out_ready = 1'b0;
        accept(12'h123, 12'h456);
        wait_valid(lat);
        check("bp_latency", lat, 3);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_result_held", {19'b0, bus.result}, 32'h0579);
            check("bp_out_valid_held", {31'b0, bus.out_valid}, 32'h1);
            check("bp_in_ready_low", {31'b0, bus.in_ready}, 32'h0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_released_valid", {31'b0, bus.out_valid}, 32'h0);
        check("bp_released_in_ready", {31'b0, bus.in_ready}, 32'h1);

        // back-to-back with in_valid held high through the first operation
        @(negedge clk);
        bus.vector0  = 12'h800;
        bus.vector1  = 12'h800;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.vector0 = 12'h001;
        bus.vector1 = 12'h002;
        wait_valid(lat);
        check("b2b_first_latency", lat, 3);
        check("b2b_first_result", {19'b0, bus.result}, 32'h1000);
        @(posedge clk);
        #1;
        check("b2b_no_accept_in_done", {31'b0, bus.busy}, 32'h0);
        check("b2b_in_ready_idle", {31'b0, bus.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("b2b_second_accepted", {31'b0, bus.busy}, 32'h1);
        wait_valid(lat);
        check("b2b_second_latency", lat, LatSmall);
        check("b2b_second_result", {19'b0, bus.result}, 32'h0003);
        @(posedge clk);
        #1;

        // small operands: early finish only when the option is built in
        @(negedge clk);
        accept(12'h003, 12'h004);
        wait_valid(lat);
        check("small_latency", lat, LatSmall);
        check("small_result", {19'b0, bus.result}, 32'h0007);
        @(posedge clk);
        #1;

        // reset while a result is waiting in DONE aborts it
        @(negedge clk);
        bus.out_ready = 1'b0;
        accept(12'h0FF, 12'h001);
        wait_valid(lat);
        check("abort_pre_result", {19'b0, bus.result}, 32'h0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("abort_result", {19'b0, bus.result}, 32'h0);
        check("abort_busy", {31'b0, bus.busy}, 32'h0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("abort_in_ready", {31'b0, bus.in_ready}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_pulse", {31'b0, bus.out_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
